// File: rtl/ldtu_bsl_calib_pkg.sv
// ============================================================================
// Module      : ldtu_bsl_pkg
// Description : Shared widths, limits and FSM encoding for the LiTe-DTU
//               baseline calibration engine.
// Contents    : Nbits_12      raw ADC sample width
//               Nbits_8       baseline value width
//               NAVG_MAX_LOG2 log2 of the largest averaging window
//               ACC_W         accumulator width (never overflows)
//               BSL_MAX       saturation ceiling for the baseline
//               bsl_state_t   calibration FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ldtu_bsl_pkg;

    localparam int Nbits_12      = 12;
    localparam int Nbits_8       = 8;
    localparam int NAVG_MAX_LOG2 = 11;
    localparam int ACC_W         = Nbits_12 + NAVG_MAX_LOG2;

    localparam logic [Nbits_8-1:0] BSL_MAX = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACCUM  = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } bsl_state_t;

endpackage : ldtu_bsl_pkg

`default_nettype wire

// File: rtl/ldtu_bsl_calib.sv
// ============================================================================
// Module      : ldtu_bsl_calib
// Description : Baseline calibration engine for one LiTe-DTU gain channel.
//               On calib_start it discards settle_cnt valid samples, then
//               averages 2^(navg_sel+4) valid samples, rounds half-up and
//               saturates the mean to 8 bits, and publishes it atomically.
// Ports       : CLK         channel ADC clock
//               rst         synchronous active-high reset
//               calib_start one-cycle request to begin a calibration
//               calib_abort cancel the running calibration
//               sample_vld  DATA12 carries a valid sample
//               DATA12      raw 12-bit ADC sample
//               navg_sel    window N = 2^(navg_sel+4), 16..2048
//               settle_cnt  valid samples discarded before accumulating
//               BSL_VAL     baseline result
//               bsl_vld     at least one completed result is held
//               calib_busy  calibration in progress
//               calib_done  one-cycle pulse when BSL_VAL is updated
//               bsl_sat     last result was clipped to 255
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ldtu_bsl_calib
    import ldtu_bsl_pkg::*;
(
    input  logic                CLK,
    input  logic                rst,
    input  logic                calib_start,
    input  logic                calib_abort,
    input  logic                sample_vld,
    input  logic [Nbits_12-1:0] DATA12,
    input  logic [2:0]          navg_sel,
    input  logic [3:0]          settle_cnt,
    output logic [Nbits_8-1:0]  BSL_VAL,
    output logic                bsl_vld,
    output logic                calib_busy,
    output logic                calib_done,
    output logic                bsl_sat
);

    bsl_state_t                 r_state;
    logic [ACC_W-1:0]           r_acc;
    logic [NAVG_MAX_LOG2-1:0]   r_cnt;
    logic [2:0]                 r_navg_sel;
    logic [3:0]                 r_settle;

    logic [3:0]                 w_k;
    logic [NAVG_MAX_LOG2:0]     w_last_idx;
    logic                       w_accum_last;
    logic                       w_settle_last;
    logic [ACC_W:0]             w_half;
    logic [ACC_W:0]             w_sum;
    logic [ACC_W:0]             w_avg;
    logic                       w_over;

    // Window exponent k = navg_sel + 4, from the value latched at start.
    assign w_k = {1'b0, r_navg_sel} + 4'd4;

    // Terminal compare against N-1 keeps the 11-bit counter from wrapping
    // even for the 2048-sample window.
    assign w_last_idx    = (12'd1 << w_k) - 12'd1;
    assign w_accum_last  = ({1'b0, r_cnt} == w_last_idx);
    assign w_settle_last = ((r_cnt + 11'd1) == {7'd0, r_settle});

    // Round half-up: add 2^(k-1) before the shift. One extra bit of headroom
    // keeps the rounding add exact.
    assign w_half = {{ACC_W{1'b0}}, 1'b1} << (w_k - 4'd1);
    assign w_sum  = {1'b0, r_acc} + w_half;
    assign w_avg  = w_sum >> w_k;
    assign w_over = |w_avg[ACC_W:Nbits_8];

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_navg_sel <= '0;
            r_settle   <= '0;
            BSL_VAL    <= '0;
            bsl_vld    <= 1'b0;
            calib_busy <= 1'b0;
            calib_done <= 1'b0;
            bsl_sat    <= 1'b0;
        end else begin
            calib_done <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    // Abort outranks a simultaneous start.
                    if (calib_start && !calib_abort) begin
                        r_navg_sel <= navg_sel;
                        r_settle   <= settle_cnt;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        calib_busy <= 1'b1;
                        r_state    <= (settle_cnt != 4'd0) ? S_SETTLE : S_ACCUM;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_SETTLE: begin
                    if (calib_abort) begin
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        calib_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (sample_vld) begin
                        if (w_settle_last) begin
                            r_cnt   <= '0;
                            r_state <= S_ACCUM;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                end

                S_ACCUM: begin
                    if (calib_abort) begin
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        calib_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (sample_vld) begin
                        r_acc <= r_acc + {{NAVG_MAX_LOG2{1'b0}}, DATA12};
                        if (w_accum_last) begin
                            r_cnt   <= '0;
                            r_state <= S_ROUND;
                        end else begin
                            r_cnt <= r_cnt + 11'd1;
                        end
                    end
                end

                S_ROUND: begin
                    r_acc      <= '0;
                    calib_busy <= 1'b0;
                    if (calib_abort) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        // Result fields change together in this one edge.
                        BSL_VAL    <= w_over ? BSL_MAX : w_avg[Nbits_8-1:0];
                        bsl_sat    <= w_over;
                        bsl_vld    <= 1'b1;
                        calib_done <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end

                default: begin
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    calib_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule : ldtu_bsl_calib

`default_nettype wire

// File: tb/tb_ldtu_bsl_calib.sv
// ============================================================================
// Module      : tb_ldtu_bsl_calib
// Description : Scoreboard bench for ldtu_bsl_calib. Stimulus pushes the
//               hand-computed result and completion cycle; a monitor pops
//               and compares on every calib_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ldtu_bsl_calib;

    logic        CLK = 1'b0;
    logic        rst;
    logic        calib_start;
    logic        calib_abort;
    logic        sample_vld;
    logic [11:0] DATA12;
    logic [2:0]  navg_sel;
    logic [3:0]  settle_cnt;
    logic [7:0]  BSL_VAL;
    logic        bsl_vld;
    logic        calib_busy;
    logic        calib_done;
    logic        bsl_sat;

    always #5 CLK = ~CLK;

    ldtu_bsl_calib dut (
        .CLK         (CLK),
        .rst         (rst),
        .calib_start (calib_start),
        .calib_abort (calib_abort),
        .sample_vld  (sample_vld),
        .DATA12      (DATA12),
        .navg_sel    (navg_sel),
        .settle_cnt  (settle_cnt),
        .BSL_VAL     (BSL_VAL),
        .bsl_vld     (bsl_vld),
        .calib_busy  (calib_busy),
        .calib_done  (calib_done),
        .bsl_sat     (bsl_sat)
    );

    typedef struct {
        int bsl;
        int sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (!rst && calib_done) begin
            if (q.size() == 0) begin
                chk("unexpected_calib_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("BSL_VAL", int'(BSL_VAL), e.bsl);
                chk("bsl_sat", int'(bsl_sat), e.sat);
                chk("done_cycle", cyc, e.cyc);
                chk("bsl_vld_at_done", int'(bsl_vld), 1);
                chk("busy_at_done", int'(calib_busy), 0);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input int n, input int s);
        calib_start = 1'b1;
        navg_sel    = 3'(n);
        settle_cnt  = 4'(s);
        step();
        calib_start = 1'b0;
    endtask

    task automatic samp(input int d);
        sample_vld = 1'b1;
        DATA12     = 12'(d);
        last_cyc   = cyc;
        step();
        sample_vld = 1'b0;
    endtask

    task automatic gap();
        sample_vld = 1'b0;
        step();
    endtask

    task automatic expect_res(input int bsl, input int sat);
        exp_t e;
        e.bsl = bsl;
        e.sat = sat;
        e.cyc = last_cyc + 2;
        q.push_back(e);
    endtask

    // Bounded wait for all expected results to be consumed.
    task automatic drain(input string name);
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        chk(name, q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; calib_start = 1'b0; calib_abort = 1'b0; sample_vld = 1'b0;
        DATA12 = '0; navg_sel = '0; settle_cnt = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_BSL_VAL", int'(BSL_VAL), 0);
        chk("rst_bsl_vld", int'(bsl_vld), 0);
        chk("rst_busy", int'(calib_busy), 0);
        chk("rst_sat", int'(bsl_sat), 0);
        chk("rst_done", int'(calib_done), 0);

        // Start and abort together in IDLE: abort wins
        calib_start = 1'b1; calib_abort = 1'b1;
        step();
        calib_start = 1'b0; calib_abort = 1'b0;
        chk("start_abort_busy", int'(calib_busy), 0);

        // Constant 100, N=16
        start_run(0, 0);
        chk("busy_after_start", int'(calib_busy), 1);
        chk("vld_before_first", int'(bsl_vld), 0);
        repeat (16) samp(100);
        expect_res(100, 0);
        drain("drain_const100");
        chk("vld_after_first", int'(bsl_vld), 1);
        chk("busy_after_done", int'(calib_busy), 0);

        // Rounding: 10/11 alternating -> 10.5 -> 11
        start_run(0, 0);
        for (int i = 0; i < 16; i++) samp((i % 2) ? 11 : 10);
        expect_res(11, 0);
        drain("drain_round_up");

        // Rounding: sum 159 -> 9.94 -> 10
        start_run(0, 0);
        for (int i = 0; i < 16; i++) samp((i == 5) ? 9 : 10);
        expect_res(10, 0);
        drain("drain_round_down");

        // Max window, full-scale input: saturates without overflow
        start_run(7, 0);
        repeat (2048) samp(4095);
        expect_res(255, 1);
        drain("drain_max_window");

        // 300 average with N=16 saturates
        start_run(0, 0);
        repeat (16) samp(300);
        expect_res(255, 1);
        drain("drain_sat300");

        // Settle 3 with 1010 valid pattern; 4095 samples discarded
        start_run(0, 3);
        repeat (3) begin samp(4095); gap(); end
        repeat (16) begin samp(50); gap(); end
        expect_res(50, 0);
        drain("drain_settle_gaps");
        chk("sat_cleared", int'(bsl_sat), 0);

        // Prior result of 100, then an aborted run of 200
        start_run(0, 0);
        repeat (16) samp(100);
        expect_res(100, 0);
        drain("drain_prior100");
        start_run(0, 0);
        repeat (8) samp(200);
        calib_abort = 1'b1;
        step();
        calib_abort = 1'b0;
        chk("abort_busy", int'(calib_busy), 0);
        repeat (20) step();
        chk("abort_BSL_VAL", int'(BSL_VAL), 100);
        chk("abort_bsl_vld", int'(bsl_vld), 1);
        chk("abort_sat", int'(bsl_sat), 0);

        // Start while busy is ignored; original N=16 is kept
        start_run(0, 0);
        repeat (4) samp(40);
        calib_start = 1'b1;
        navg_sel    = 3'd1;
        samp(40);
        calib_start = 1'b0;
        repeat (11) samp(40);
        chk("midrun_BSL_VAL_held", int'(BSL_VAL), 100);
        chk("midrun_vld_held", int'(bsl_vld), 1);
        expect_res(40, 0);
        drain("drain_start_ignored");

        // Reset mid-ACCUM
        start_run(0, 0);
        repeat (5) samp(123);
        rst = 1'b1;
        step();
        chk("midrst_BSL_VAL", int'(BSL_VAL), 0);
        chk("midrst_bsl_vld", int'(bsl_vld), 0);
        chk("midrst_busy", int'(calib_busy), 0);
        chk("midrst_sat", int'(bsl_sat), 0);
        rst = 1'b0;
        step();
        start_run(0, 0);
        repeat (16) samp(77);
        expect_res(77, 0);
        drain("drain_after_rst");

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ldtu_bsl_calib

`default_nettype wire
